// File: rtl/enc_pack_scheduler_if.sv
// enc_pack_scheduler_if: control, pack strobe and capture handshake bundle between encoder control, pack array and scheduler
interface enc_pack_scheduler_if #(
  parameter int NUM_PACKS = 62,
  parameter int PACK_W = NUM_PACKS > 1 ? $clog2(NUM_PACKS) : 1
);
  logic start;
  logic abort;
  logic [NUM_PACKS-1:0] pack_start;
  logic cap_valid;
  logic cap_ready;
  logic [PACK_W-1:0] cap_idx;
  logic busy;
  logic done;
  logic aborted;
  modport master(input start, abort, cap_ready, output pack_start, cap_valid, cap_idx, busy, done, aborted);
  modport slave(output start, abort, cap_ready, input pack_start, cap_valid, cap_idx, busy, done, aborted);
endinterface

// File: rtl/enc_pack_scheduler.sv
// enc_pack_scheduler: strobes one binder pack at a time (pack_start), waits BIND_LATENCY, presents it on cap_valid/cap_ready/cap_idx; start/abort in, busy/done/aborted out
module enc_pack_scheduler #(
  parameter int NUM_PACKS = 62,
  parameter int BIND_LATENCY = 2,
  parameter int PACK_W = NUM_PACKS > 1 ? $clog2(NUM_PACKS) : 1
) (
  input logic clk,
  input logic nrst,
  enc_pack_scheduler_if.master bus
);
  localparam int WW = BIND_LATENCY > 2 ? $clog2(BIND_LATENCY - 1) : 1;
  localparam logic [WW-1:0] WAIT_INIT = BIND_LATENCY > 1 ? WW'(BIND_LATENCY - 2) : '0;
  localparam logic [PACK_W-1:0] LAST = PACK_W'(NUM_PACKS - 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, CAPTURE, DONE} state_t;
  state_t state, state_d;
  logic [PACK_W-1:0] pack_idx, pack_idx_d, cap_idx;
  logic [WW-1:0] wait_cnt, wait_cnt_d;
  logic [NUM_PACKS-1:0] pack_start;
  logic aborted, abort_hit;
  assign abort_hit = bus.abort && state != IDLE;
  always_comb begin
    state_d = state;
    pack_idx_d = pack_idx;
    wait_cnt_d = wait_cnt;
    if (abort_hit) begin
      state_d = IDLE;
      pack_idx_d = '0;
    end else begin
      case (state)
        IDLE: if (bus.start && !bus.abort) begin
          pack_idx_d = '0;
          state_d = LAUNCH;
        end
        LAUNCH: begin
          state_d = BIND_LATENCY == 1 ? CAPTURE : WAIT;
          wait_cnt_d = WAIT_INIT;
        end
        WAIT: begin
          state_d = wait_cnt == '0 ? CAPTURE : WAIT;
          wait_cnt_d = wait_cnt == '0 ? wait_cnt : wait_cnt - 1'b1;
        end
        CAPTURE: if (bus.cap_ready) begin
          state_d = pack_idx == LAST ? DONE : LAUNCH;
          pack_idx_d = pack_idx == LAST ? pack_idx : pack_idx + 1'b1;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (nrst) begin
      state <= IDLE;
      pack_idx <= '0;
      wait_cnt <= '0;
      cap_idx <= '0;
      pack_start <= '0;
      aborted <= 1'b0;
    end else begin
      state <= state_d;
      pack_idx <= pack_idx_d;
      wait_cnt <= wait_cnt_d;
      cap_idx <= state_d == CAPTURE ? pack_idx_d : cap_idx;
      pack_start <= state_d == LAUNCH ? NUM_PACKS'(1) << pack_idx_d : '0;
      aborted <= abort_hit;
    end
  end
  assign bus.pack_start = pack_start;
  assign bus.cap_valid = state == CAPTURE;
  assign bus.cap_idx = cap_idx;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.aborted = aborted;
endmodule

// File: tb/tb_enc_pack_scheduler.sv
// tb_enc_pack_scheduler: directed checks of pack sequencing, stalls, latency 1, abort, reset and strobe exclusivity
module tb_enc_pack_scheduler;
  logic clk = 1'b0;
  logic nrst;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  enc_pack_scheduler_if #(.NUM_PACKS(4), .PACK_W(2)) a();
  enc_pack_scheduler_if #(.NUM_PACKS(3), .PACK_W(2)) b();
  enc_pack_scheduler #(.NUM_PACKS(4), .BIND_LATENCY(2), .PACK_W(2)) dut_a(.clk(clk), .nrst(nrst), .bus(a.master));
  enc_pack_scheduler #(.NUM_PACKS(3), .BIND_LATENCY(1), .PACK_W(2)) dut_b(.clk(clk), .nrst(nrst), .bus(b.master));
  function automatic logic [9:0] obs_a();
    return {a.pack_start, a.cap_valid, a.cap_idx, a.busy, a.done, a.aborted};
  endfunction
  function automatic logic [8:0] obs_b();
    return {b.pack_start, b.cap_valid, b.cap_idx, b.busy, b.done, b.aborted};
  endfunction
  task automatic pulse_start_a();
    a.start = 1'b1;
    @(negedge clk);
    a.start = 1'b0;
  endtask
  task automatic test_reset();
    vectors++;
    if (obs_a() !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_a got=%b exp=%b", obs_a(), 10'b0);
    end
    vectors++;
    if (obs_b() !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_b got=%b exp=%b", obs_b(), 9'b0);
    end
  endtask
  task automatic test_nominal();
    logic [3:0] ps;
    logic [1:0] ci;
    logic [9:0] e;
    pulse_start_a();
    for (int c = 1; c <= 14; c++) begin
      ps = c == 1 ? 4'b0001 : c == 4 ? 4'b0010 : c == 7 ? 4'b0100 : c == 10 ? 4'b1000 : 4'b0000;
      ci = c < 6 ? 2'd0 : c < 9 ? 2'd1 : c < 12 ? 2'd2 : 2'd3;
      e = {ps, c == 3 || c == 6 || c == 9 || c == 12, ci, c <= 13, c == 13, 1'b0};
      vectors++;
      if (obs_a() !== e) begin
        miscompares++;
        $display("FAIL nominal c=%0d got=%b exp=%b", c, obs_a(), e);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_stall();
    logic [3:0] ps;
    logic [1:0] ci;
    logic [9:0] e;
    pulse_start_a();
    for (int c = 1; c <= 19; c++) begin
      ps = c == 1 ? 4'b0001 : c == 4 ? 4'b0010 : c == 12 ? 4'b0100 : c == 15 ? 4'b1000 : 4'b0000;
      ci = c < 3 ? 2'd3 : c < 6 ? 2'd0 : c < 14 ? 2'd1 : c < 17 ? 2'd2 : 2'd3;
      e = {ps, c == 3 || (c >= 6 && c <= 11) || c == 14 || c == 17, ci, c <= 18, c == 18, 1'b0};
      vectors++;
      if (obs_a() !== e) begin
        miscompares++;
        $display("FAIL stall c=%0d got=%b exp=%b", c, obs_a(), e);
      end
      a.cap_ready = !(c >= 6 && c <= 10);
      @(negedge clk);
    end
    a.cap_ready = 1'b1;
  endtask
  task automatic test_lat1();
    logic [2:0] ps;
    logic [1:0] ci;
    logic [8:0] e;
    b.start = 1'b1;
    @(negedge clk);
    b.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      ps = c == 1 ? 3'b001 : c == 3 ? 3'b010 : c == 5 ? 3'b100 : 3'b000;
      ci = c < 4 ? 2'd0 : c < 6 ? 2'd1 : 2'd2;
      e = {ps, c == 2 || c == 4 || c == 6, ci, c <= 7, c == 7, 1'b0};
      vectors++;
      if (obs_b() !== e) begin
        miscompares++;
        $display("FAIL lat1 c=%0d got=%b exp=%b", c, obs_b(), e);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_abort_wait();
    logic [3:0] ps;
    logic [1:0] ci;
    logic [9:0] e;
    pulse_start_a();
    for (int c = 1; c <= 10; c++) begin
      ps = c == 1 ? 4'b0001 : c == 4 ? 4'b0010 : c == 7 ? 4'b0100 : 4'b0000;
      ci = c < 3 ? 2'd3 : c < 6 ? 2'd0 : 2'd1;
      e = {ps, c == 3 || c == 6, ci, c <= 8, 1'b0, c == 9};
      vectors++;
      if (obs_a() !== e) begin
        miscompares++;
        $display("FAIL abort_wait c=%0d got=%b exp=%b", c, obs_a(), e);
      end
      a.abort = c == 8;
      @(negedge clk);
    end
    pulse_start_a();
    for (int c = 1; c <= 4; c++) begin
      ps = c == 1 ? 4'b0001 : 4'b0000;
      ci = c < 3 ? 2'd1 : 2'd0;
      e = {ps, c == 3, ci, c <= 3, 1'b0, c == 4};
      vectors++;
      if (obs_a() !== e) begin
        miscompares++;
        $display("FAIL restart c=%0d got=%b exp=%b", c, obs_a(), e);
      end
      a.abort = c == 3;
      @(negedge clk);
    end
  endtask
  task automatic test_abort_last();
    logic [3:0] ps;
    logic [1:0] ci;
    logic [9:0] e;
    pulse_start_a();
    for (int c = 1; c <= 14; c++) begin
      ps = c == 1 ? 4'b0001 : c == 4 ? 4'b0010 : c == 7 ? 4'b0100 : c == 10 ? 4'b1000 : 4'b0000;
      ci = c < 6 ? 2'd0 : c < 9 ? 2'd1 : c < 12 ? 2'd2 : 2'd3;
      e = {ps, c == 3 || c == 6 || c == 9 || c == 12, ci, c <= 12, 1'b0, c == 13};
      vectors++;
      if (obs_a() !== e) begin
        miscompares++;
        $display("FAIL abort_last c=%0d got=%b exp=%b", c, obs_a(), e);
      end
      a.start = c == 5;
      a.abort = c == 12;
      @(negedge clk);
    end
    a.start = 1'b1;
    a.abort = 1'b1;
    @(negedge clk);
    a.start = 1'b0;
    a.abort = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      e = {4'b0000, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0};
      vectors++;
      if (obs_a() !== e) begin
        miscompares++;
        $display("FAIL start_abort_idle c=%0d got=%b exp=%b", c, obs_a(), e);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_reset_mid();
    logic [3:0] ps;
    logic [1:0] ci;
    logic [9:0] e;
    pulse_start_a();
    for (int c = 1; c <= 8; c++) begin
      ps = c == 1 ? 4'b0001 : c == 4 ? 4'b0010 : 4'b0000;
      ci = c < 3 ? 2'd3 : c < 6 ? 2'd0 : c < 7 ? 2'd1 : 2'd0;
      e = {ps, c == 3 || c == 6, ci, c <= 6, 1'b0, 1'b0};
      vectors++;
      if (obs_a() !== e) begin
        miscompares++;
        $display("FAIL reset_mid c=%0d got=%b exp=%b", c, obs_a(), e);
      end
      a.cap_ready = c < 6;
      nrst = c == 6;
      @(negedge clk);
    end
    a.cap_ready = 1'b1;
  endtask
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      vectors++;
      assert ($onehot0(a.pack_start));
      if (!$onehot0(a.pack_start) || (a.pack_start != 4'b0 && (a.cap_valid || !a.busy))) begin
        miscompares++;
        $display("FAIL strobe c=%0d pack_start=%b cap_valid=%b busy=%b", c, a.pack_start, a.cap_valid, a.busy);
      end
      a.cap_ready = 1'($urandom_range(0, 1));
      a.start = $urandom_range(0, 3) == 0;
      a.abort = $urandom_range(0, 30) == 0;
      @(negedge clk);
    end
    a.start = 1'b0;
    a.abort = 1'b0;
  endtask
  initial begin
    nrst = 1'b1;
    a.start = 1'b0;
    a.abort = 1'b0;
    a.cap_ready = 1'b1;
    b.start = 1'b0;
    b.abort = 1'b0;
    b.cap_ready = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    nrst = 1'b0;
    @(negedge clk);
    test_nominal();
    test_stall();
    test_lat1();
    test_abort_wait();
    test_abort_last();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
